// File: rtl/mxrv_bus_arb_pkg.sv
// Shared defines for the mxrv bus arbiter: word width, enable/disable levels,
// arbiter state encoding and the full byte-enable constant.
`ifndef PORT_WORD_WIDTH
`define PORT_WORD_WIDTH 32
`endif
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

package mxrv_bus_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_LS = 2'd2;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mxrv_bus_arb.sv
// Two-master (fetch, load/store) arbiter onto a single memory port with at most
// one transaction in flight and a starvation guard for instruction fetch.
`ifndef PORT_WORD_WIDTH
`define PORT_WORD_WIDTH 32
`endif
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

module mxrv_bus_arb
  import mxrv_bus_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_req_i,
  input  logic [`PORT_WORD_WIDTH-1:0] if_addr_i,
  output logic                        if_gnt_o,
  output logic                        if_rvalid_o,
  output logic [`PORT_WORD_WIDTH-1:0] if_rdata_o,
  input  logic                        flush_i,
  input  logic                        ls_req_i,
  input  logic                        ls_we_i,
  input  logic [`PORT_WORD_WIDTH-1:0] ls_addr_i,
  input  logic [`PORT_WORD_WIDTH-1:0] ls_wdata_i,
  input  logic [3:0]                  ls_be_i,
  output logic                        ls_gnt_o,
  output logic                        ls_rvalid_o,
  output logic [`PORT_WORD_WIDTH-1:0] ls_rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [`PORT_WORD_WIDTH-1:0] mem_addr_o,
  output logic [`PORT_WORD_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]                  mem_be_o,
  input  logic                        mem_gnt_i,
  input  logic                        mem_rvalid_i,
  input  logic [`PORT_WORD_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

  logic [1:0]                  state_q, state_d;
  logic [CntW-1:0]             starve_q, starve_d;
  logic                        drop_q, drop_d;
  logic                        if_rvalid_q, if_rvalid_d;
  logic                        ls_rvalid_q, ls_rvalid_d;
  logic [`PORT_WORD_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [`PORT_WORD_WIDTH-1:0] ls_rdata_q, ls_rdata_d;

  logic idle, sel_if, sel_ls;

  assign idle   = (state_q == ST_IDLE) && !rst;
  // Fetch only beats a pending load/store once the starve counter has saturated.
  assign sel_if = if_req_i && (!ls_req_i || (starve_q == StarveMaxC));
  assign sel_ls = ls_req_i && !sel_if;

  always_comb begin
    mem_req_o   = idle && (sel_if || sel_ls);
    mem_we_o    = sel_if ? `Disable : ls_we_i;
    mem_addr_o  = sel_if ? if_addr_i : ls_addr_i;
    mem_wdata_o = sel_if ? '0 : ls_wdata_i;
    mem_be_o    = sel_if ? BE_ALL : ls_be_i;
    if_gnt_o    = idle && sel_if && mem_gnt_i;
    ls_gnt_o    = idle && sel_ls && mem_gnt_i;
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    drop_d      = drop_q;
    if_rvalid_d = `Disable;
    ls_rvalid_d = `Disable;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (if_gnt_o) begin
          state_d  = ST_BUSY_IF;
          drop_d   = flush_i;
          starve_d = '0;
        end else if (ls_gnt_o) begin
          state_d = ST_BUSY_LS;
          if (if_req_i && (starve_q != StarveMaxC)) starve_d = starve_q + CntW'(1);
        end
      end
      ST_BUSY_IF: begin
        if (flush_i) drop_d = `Enable;
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
          drop_d  = `Disable;
          // A killed fetch leaves the previous instruction word visible.
          if (!drop_q && !flush_i) begin
            if_rvalid_d = `Enable;
            if_rdata_d  = mem_rdata_i;
          end
        end
      end
      ST_BUSY_LS: begin
        if (mem_rvalid_i) begin
          state_d     = ST_IDLE;
          ls_rvalid_d = `Enable;
          ls_rdata_d  = mem_rdata_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mxrv_bus_arb.sv
// Random and directed stimulus for mxrv_bus_arb, checked every cycle against a
// transaction-level reference model of the arbiter.
`ifndef PORT_WORD_WIDTH
`define PORT_WORD_WIDTH 32
`endif

module tb_mxrv_bus_arb;

  localparam int StarveMax = 4;

  logic        clk, rst;
  logic        if_req_i, if_gnt_o, if_rvalid_o, flush_i;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_addr_i, ls_wdata_i, ls_rdata_o;
  logic [3:0]  ls_be_i, mem_be_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mxrv_bus_arb #(.STARVE_MAX(StarveMax)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 fetch, 2 load/store), how many
  // load/store grants fetch has waited through, and whether the fetch is killed.
  int          owner, starve;
  bit          drop;
  bit          e_if_rv, e_ls_rv, e_if_gnt, e_ls_gnt;
  logic [31:0] e_if_rd, e_ls_rd;
  bit          g_if, g_ls;

  task automatic model_reset();
    owner = 0; starve = 0; drop = 0;
    e_if_rv = 0; e_ls_rv = 0; e_if_rd = '0; e_ls_rd = '0;
  endtask

  task automatic check_outputs();
    bit pick_if, pick_ls, e_req;
    pick_if  = if_req_i && (!ls_req_i || starve == StarveMax);
    pick_ls  = ls_req_i && !pick_if;
    e_req    = !rst && owner == 0 && (pick_if || pick_ls);
    e_if_gnt = e_req && pick_if && mem_gnt_i;
    e_ls_gnt = e_req && pick_ls && mem_gnt_i;
    check_eq("mem_req", {31'd0, mem_req_o}, {31'd0, e_req});
    check_eq("if_gnt", {31'd0, if_gnt_o}, {31'd0, e_if_gnt});
    check_eq("ls_gnt", {31'd0, ls_gnt_o}, {31'd0, e_ls_gnt});
    if (e_req) begin
      check_eq("mem_addr", mem_addr_o, pick_if ? if_addr_i : ls_addr_i);
      check_eq("mem_we", {31'd0, mem_we_o}, {31'd0, pick_if ? 1'b0 : ls_we_i});
      check_eq("mem_be", {28'd0, mem_be_o}, {28'd0, pick_if ? 4'hF : ls_be_i});
      if (pick_ls) check_eq("mem_wdata", mem_wdata_o, ls_wdata_i);
    end
    check_eq("if_rvalid", {31'd0, if_rvalid_o}, {31'd0, e_if_rv});
    check_eq("ls_rvalid", {31'd0, ls_rvalid_o}, {31'd0, e_ls_rv});
    check_eq("if_rdata", if_rdata_o, e_if_rd);
    check_eq("ls_rdata", ls_rdata_o, e_ls_rd);
    g_if = if_gnt_o;
    g_ls = ls_gnt_o;
  endtask

  task automatic model_next();
    bit nif = 0;
    bit nls = 0;
    if (rst) begin
      model_reset();
    end else begin
      case (owner)
        0: begin
          if (e_if_gnt) begin
            owner = 1; drop = flush_i; starve = 0;
          end else if (e_ls_gnt) begin
            owner = 2;
            if (if_req_i && starve < StarveMax) starve++;
          end
        end
        1: begin
          if (flush_i) drop = 1;
          if (mem_rvalid_i) begin
            if (!drop) begin nif = 1; e_if_rd = mem_rdata_i; end
            owner = 0; drop = 0;
          end
        end
        default: begin
          if (mem_rvalid_i) begin nls = 1; e_ls_rd = mem_rdata_i; owner = 0; end
        end
      endcase
      e_if_rv = nif;
      e_ls_rv = nls;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    check_outputs();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; if_req_i = 0; if_addr_i = '0; flush_i = 0;
    ls_req_i = 0; ls_we_i = 0; ls_addr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    run_cycle();
    run_cycle();
    rst = 0;
  endtask

  logic [9:0] got_seq;

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    do_reset();

    // Fetch alone, granted at once, response one cycle later.
    if_req_i = 1; if_addr_i = 32'h0000_0010; mem_gnt_i = 1;
    run_cycle();
    check_eq("d_if_gnt_seen", {31'd0, g_if}, 32'd1);
    if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0010_0093;
    run_cycle();
    mem_rvalid_i = 0;
    run_cycle();
    check_eq("d_if_rdata", if_rdata_o, 32'h0010_0093);

    // Fetch and load together: load first, fetch right after the load response.
    if_req_i = 1; ls_req_i = 1; ls_addr_i = 32'h100; ls_be_i = 4'hF;
    run_cycle();
    check_eq("d_ls_first", {30'd0, g_if, g_ls}, 32'd1);
    ls_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    run_cycle();
    mem_rvalid_i = 0;
    run_cycle();
    check_eq("d_if_after_ls", {30'd0, g_if, g_ls}, 32'd2);
    if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
    run_cycle();
    mem_rvalid_i = 0;
    run_cycle();

    // Flush while fetch is outstanding, then a normal fetch.
    if_req_i = 1; if_addr_i = 32'h40;
    run_cycle();
    if_req_i = 0; flush_i = 1;
    run_cycle();
    flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    run_cycle();
    mem_rvalid_i = 0;
    run_cycle();
    check_eq("d_flush_no_rv", {31'd0, if_rvalid_o}, 32'd0);
    if_req_i = 1; if_addr_i = 32'h80;
    run_cycle();
    check_eq("d_fetch_after_flush", {31'd0, g_if}, 32'd1);
    if_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0073;
    run_cycle();
    mem_rvalid_i = 0;
    run_cycle();

    // Grant withheld for 3 cycles, then given.
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h200; ls_wdata_i = 32'hCAFE_F00D; ls_be_i = 4'h3;
    mem_gnt_i = 0;
    for (int i = 0; i < 3; i++) run_cycle();
    mem_gnt_i = 1;
    run_cycle();
    check_eq("d_ls_gnt_4th", {31'd0, g_ls}, 32'd1);
    ls_req_i = 0;
    // Reset mid load/store, then a late response.
    rst = 1;
    run_cycle();
    rst = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h5555_AAAA;
    run_cycle();
    mem_rvalid_i = 0;
    run_cycle();
    check_eq("d_late_rv_ignored", {31'd0, ls_rvalid_o}, 32'd0);

    // Starvation: both masters always requesting, memory always answering.
    do_reset();
    if_req_i = 1; ls_req_i = 1; ls_we_i = 0; mem_gnt_i = 1; mem_rvalid_i = 1;
    got_seq = '0;
    for (int n = 0, c = 0; n < 10 && c < 60; c++) begin
      run_cycle();
      if (g_if || g_ls) begin
        got_seq[n] = g_if;
        n++;
      end
    end
    check_eq("d_starve_seq", {22'd0, got_seq}, {22'd0, 10'b10000_10000});

    // Random traffic.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 79) == 0);
      if_req_i     = ($urandom_range(0, 2) != 0);
      if_addr_i    = $urandom;
      flush_i      = ($urandom_range(0, 5) == 0);
      ls_req_i     = ($urandom_range(0, 1) != 0);
      ls_we_i      = $urandom_range(0, 1);
      ls_addr_i    = $urandom;
      ls_wdata_i   = $urandom;
      ls_be_i      = 4'($urandom);
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rvalid_i = (owner != 0) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) == 0);
      mem_rdata_i  = $urandom;
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mxrv_bus_arb.md
MXRV_BUS_ARB -- requirements
Module: mxrv_bus_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive load/store grants allowed while fetch waits before fetch is forced.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req_i  input  1  fetch request.
REQ-005 SHALL have port if_addr_i  input  `PORT_WORD_WIDTH  fetch address (PC).
REQ-006 SHALL have port if_gnt_o  output  1  fetch request accepted this cycle.
REQ-007 SHALL have ports if_rvalid_o (output, 1) and if_rdata_o (output, `PORT_WORD_WIDTH): registered instruction return.
REQ-008 SHALL have port flush_i  input  1  jump/flush; kills the pending fetch response.
REQ-009 SHALL have ports ls_req_i, ls_we_i (input, 1 each), ls_addr_i and ls_wdata_i (input, `PORT_WORD_WIDTH), and ls_be_i (input, 4): load/store request.
REQ-010 SHALL have ports ls_gnt_o and ls_rvalid_o (output, 1 each) and ls_rdata_o (output, `PORT_WORD_WIDTH).
REQ-011 SHALL have ports mem_req_o and mem_we_o (output, 1 each), mem_addr_o and mem_wdata_o (output, `PORT_WORD_WIDTH), and mem_be_o (output, 4): shared memory port.
REQ-012 SHALL have ports mem_gnt_i and mem_rvalid_i (input, 1 each) and mem_rdata_i (input, `PORT_WORD_WIDTH).

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS, allowing at most one outstanding memory transaction.
REQ-014 In IDLE, SHALL drive mem_req_o with the selected master's request fields, combinationally; mem_req_o=0 in BUSY states.
REQ-015 Selection: load/store wins over fetch, unless starve counter == STARVE_MAX and if_req_i=1, in which case fetch wins.
REQ-016 Fetch fields drive mem_we_o=0 and mem_be_o=4'hF.
REQ-017 Grant: x_gnt_o = IDLE & selected_x & mem_gnt_i, asserted the same cycle; the FSM moves to BUSY_IF/BUSY_LS on the next edge.
REQ-018 Without mem_gnt_i, SHALL hold the request and stay IDLE, re-arbitrating every cycle.
REQ-019 In BUSY_x, on mem_rvalid_i, SHALL register mem_rdata_i into x_rdata_o, pulse x_rvalid_o for one cycle on the next cycle, and return to IDLE; earliest next grant is that same following cycle.
REQ-020 Writes SHALL also complete via ls_rvalid_o; ls_rdata_o is don't-care for writes but is still loaded.
REQ-021 Starve counter (width clog2(STARVE_MAX+1)): increments on each ls grant while if_req_i=1, saturating at STARVE_MAX; clears on any if grant.
REQ-022 Flush: flush_i in BUSY_IF, or in the cycle of the fetch grant, SHALL set a drop flag; the resulting response returns the FSM to IDLE with if_rvalid_o kept 0.
REQ-023 Flush coincident with fetch mem_rvalid_i SHALL suppress that response.
REQ-024 flush_i SHALL never affect BUSY_LS or ls outputs.
REQ-025 mem_rvalid_i in IDLE SHALL be ignored.
REQ-026 if_rdata_o/ls_rdata_o SHALL hold their last value between pulses.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, starve counter=0, drop flag=0, if_rvalid_o=ls_rvalid_o=0, if_rdata_o=ls_rdata_o=0.
REQ-028 Reset mid-transaction SHALL abandon it; a late mem_rvalid_i is ignored per REQ-025.
REQ-029 Outputs during reset: grants=0; mem_req_o=0.

Structure
REQ-030 State encoding constants and the be-all-ones constant SHALL live in the shared defines package beside `PORT_WORD_WIDTH, `Enable and `Disable.
REQ-031 Single module; no sub-module is required.

Verification
REQ-032 Fetch alone, addr 0x0000_0010, mem_gnt_i=1, rvalid one cycle later with 0x0010_0093 -> if_gnt_o in cycle 0; if_rvalid_o=1 with if_rdata_o=0x0010_0093 one cycle after mem_rvalid_i.
REQ-033 Simultaneous fetch and load (addr 0x100) -> ls granted first; fetch granted in the first IDLE cycle after the ls response.
REQ-034 Continuous ls_req_i and if_req_i, STARVE_MAX=4 -> 4 ls grants, then 1 if grant, then the counter restarts.
REQ-035 flush_i in BUSY_IF, then response 0xDEAD_BEEF -> if_rvalid_o stays 0, FSM back to IDLE, next fetch serviced normally.
REQ-036 mem_gnt_i held 0 for 3 cycles -> mem_req_o and fields stable, no grants; grant on the 4th cycle.
REQ-037 rst in BUSY_LS, then late mem_rvalid_i -> ls_rvalid_o stays 0, state IDLE.
